// File: rtl/pkt_capture.sv
// Capture-path ingress: stores Avalon-ST packets store-and-forward into the word FIFO,
// pads runts, allocates ring-buffer slots and issues one descriptor per packet.
module pkt_capture #(
    parameter int unsigned MAX_PKT_BYTES = 1520,
    parameter int unsigned MIN_PKT_BYTES = 64,
    parameter logic [31:0] BUF_BASE      = 32'h0000_0000,
    parameter logic [31:0] BUF_SIZE      = 32'h0010_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        capture_en,
    input  logic [31:0] st_data,
    input  logic        st_valid,
    input  logic        st_sop,
    input  logic        st_eop,
    input  logic [1:0]  st_empty,
    output logic        st_ready,
    output logic [31:0] fifo_in,
    output logic        wr_to_fifo,
    input  logic        full,
    output logic        wr_ctrl,
    input  logic        wr_ctrl_rdy,
    output logic [31:0] control,
    output logic [31:0] pkt_begin,
    output logic [31:0] pkt_end,
    output logic [31:0] write_address,
    output logic [15:0] pkt_count,
    output logic [15:0] drop_count
);

    typedef enum logic [2:0] {
        StIdle, StCapture, StDiscard, StPad, StIssue, StWaitRdy
    } state_t;

    state_t      state;
    logic [15:0] len;
    logic [15:0] stored;
    logic [31:0] offset;
    logic        truncated;
    logic        padded;
    logic        outstanding;
    logic        in_drop;

    logic        accept;
    logic        sop_beat;
    logic        cap_beat;
    logic        rdy_hit;
    logic        fits;
    logic [2:0]  beat_bytes;
    logic [15:0] len_base;
    logic [15:0] stored_base;
    logic [16:0] len_sum;
    logic [15:0] len_next;
    logic [15:0] stored_next;
    logic [32:0] slot_end;
    logic [31:0] slot_begin;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        st_ready = 1'b0;
        if (!reset) begin
            case (state)
                StCapture, StPad: st_ready = !full;
                StIssue:          st_ready = 1'b0;
                default:          st_ready = 1'b1;
            endcase
        end
    end

    assign accept   = st_valid && st_ready;
    assign sop_beat = accept && st_sop;
    // A capture beat is any beat in CAPTURE, or an enabled sop arriving in IDLE.
    assign cap_beat = accept && ((state == StCapture) ||
                                 (state == StIdle && st_sop && capture_en));

    assign beat_bytes  = st_eop ? (3'd4 - {1'b0, st_empty}) : 3'd4;
    assign len_base    = (state == StCapture) ? len : 16'd0;
    assign stored_base = (state == StCapture) ? stored : 16'd0;
    assign len_sum     = {1'b0, len_base} + {14'd0, beat_bytes};
    assign len_next    = len_sum[16] ? 16'hFFFF : len_sum[15:0];
    assign fits        = (32'(stored_base) + 32'd4) <= MAX_PKT_BYTES;
    assign stored_next = fits ? (stored_base + 16'd4) : stored_base;

    // Wrap to the ring start rather than straddle its end.
    assign slot_end   = {1'b0, offset} + {17'd0, stored};
    assign slot_begin = (slot_end > {1'b0, BUF_SIZE}) ? 32'd0 : offset;

    assign rdy_hit = wr_ctrl_rdy && outstanding && (state == StWaitRdy || state == StDiscard);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= StIdle;
            len           <= 16'd0;
            stored        <= 16'd0;
            offset        <= 32'd0;
            truncated     <= 1'b0;
            padded        <= 1'b0;
            outstanding   <= 1'b0;
            in_drop       <= 1'b0;
            fifo_in       <= 32'd0;
            wr_to_fifo    <= 1'b0;
            wr_ctrl       <= 1'b0;
            control       <= 32'd0;
            pkt_begin     <= 32'd0;
            pkt_end       <= 32'd0;
            write_address <= BUF_BASE;
            pkt_count     <= 16'd0;
            drop_count    <= 16'd0;
        end else begin
            wr_to_fifo <= 1'b0;
            wr_ctrl    <= 1'b0;

            if (rdy_hit) begin
                offset      <= pkt_end;
                outstanding <= 1'b0;
            end

            if (cap_beat) begin
                len       <= len_next;
                stored    <= stored_next;
                truncated <= (state == StCapture && truncated) || !fits;
                padded    <= st_eop && (32'(stored_next) < MIN_PKT_BYTES);
                if (fits) begin
                    wr_to_fifo <= 1'b1;
                    fifo_in    <= st_data;
                end
                state <= st_eop ? StPad : StCapture;
            end

            case (state)
                StIdle: begin
                    if (sop_beat && !capture_en) begin
                        drop_count <= sat_inc(drop_count);
                        if (!st_eop) state <= StDiscard;
                    end
                end
                StDiscard: begin
                    if (accept && st_eop) begin
                        state <= (outstanding && !rdy_hit) ? StWaitRdy : StIdle;
                    end
                end
                StPad: begin
                    // A packet starting while the previous one finishes is dropped.
                    if (sop_beat) begin
                        drop_count <= sat_inc(drop_count);
                        in_drop    <= !st_eop;
                    end else if (accept && st_eop) begin
                        in_drop <= 1'b0;
                    end
                    if (32'(stored) < MIN_PKT_BYTES) begin
                        if (!full) begin
                            wr_to_fifo <= 1'b1;
                            fifo_in    <= 32'd0;
                            stored     <= stored + 16'd4;
                        end
                    end else begin
                        state         <= StIssue;
                        wr_ctrl       <= 1'b1;
                        pkt_count     <= sat_inc(pkt_count);
                        outstanding   <= 1'b1;
                        control       <= {14'd0, padded, truncated, len};
                        pkt_begin     <= slot_begin;
                        pkt_end       <= slot_begin + {16'd0, stored};
                        write_address <= BUF_BASE + slot_begin;
                    end
                end
                StIssue: begin
                    state   <= in_drop ? StDiscard : StWaitRdy;
                    in_drop <= 1'b0;
                end
                StWaitRdy: begin
                    if (sop_beat) drop_count <= sat_inc(drop_count);
                    if (sop_beat && !st_eop) begin
                        state <= StDiscard;
                    end else if (rdy_hit) begin
                        state <= StIdle;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_capture.sv
// Directed bench for pkt_capture; a 4 KiB ring keeps the wrap case reachable.
module tb_pkt_capture;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        capture_en;
    logic [31:0] st_data;
    logic        st_valid;
    logic        st_sop;
    logic        st_eop;
    logic [1:0]  st_empty;
    logic        st_ready;
    logic [31:0] fifo_in;
    logic        wr_to_fifo;
    logic        full;
    logic        wr_ctrl;
    logic        wr_ctrl_rdy;
    logic [31:0] control;
    logic [31:0] pkt_begin;
    logic [31:0] pkt_end;
    logic [31:0] write_address;
    logic [15:0] pkt_count;
    logic [15:0] drop_count;

    int          checks = 0;
    int          failures = 0;
    int          stalls = 0;
    int          cyc = 0;
    int          errs = 0;
    logic [31:0] wq[$];

    pkt_capture #(
        .MAX_PKT_BYTES(1520),
        .MIN_PKT_BYTES(64),
        .BUF_BASE     (BASE),
        .BUF_SIZE     (32'd4096)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .capture_en   (capture_en),
        .st_data      (st_data),
        .st_valid     (st_valid),
        .st_sop       (st_sop),
        .st_eop       (st_eop),
        .st_empty     (st_empty),
        .st_ready     (st_ready),
        .fifo_in      (fifo_in),
        .wr_to_fifo   (wr_to_fifo),
        .full         (full),
        .wr_ctrl      (wr_ctrl),
        .wr_ctrl_rdy  (wr_ctrl_rdy),
        .control      (control),
        .pkt_begin    (pkt_begin),
        .pkt_end      (pkt_end),
        .write_address(write_address),
        .pkt_count    (pkt_count),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_to_fifo === 1'b1) wq.push_back(fifo_in);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "simulation timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [31:0] d, input logic sop, input logic eop,
                        input logic [1:0] emp);
        int   guard;
        logic rdy;
        guard = 0;
        @(negedge clk);
        st_valid = 1'b1;
        st_data  = d;
        st_sop   = sop;
        st_eop   = eop;
        st_empty = emp;
        forever begin
            #1;
            rdy = st_ready;
            @(posedge clk);
            if (rdy) break;
            stalls++;
            guard++;
            if (guard > 1000) begin
                checks++;
                failures++;
                $display("FAIL beat_accept observed=stalled expected=accepted");
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic send_pkt(input logic [7:0] id, input int nbytes);
        int         nbeats;
        logic [1:0] emp;
        nbeats = (nbytes + 3) / 4;
        emp    = 2'(nbeats * 4 - nbytes);
        wq.delete();
        stalls = 0;
        for (int i = 0; i < nbeats; i++) begin
            beat({id, 24'(i)}, i == 0, i == nbeats - 1, (i == nbeats - 1) ? emp : 2'd0);
        end
        @(negedge clk);
        st_valid = 1'b0;
        st_sop   = 1'b0;
        st_eop   = 1'b0;
        st_empty = 2'd0;
    endtask

    task automatic wait_issue();
        cyc = 0;
        while (wr_ctrl !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        #1;
        if (wr_ctrl !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL issue_wait observed=no_wr_ctrl expected=wr_ctrl");
        end
    endtask

    task automatic pulse_rdy();
        @(negedge clk);
        check("wr_ctrl_one_cycle", 32'(wr_ctrl), 32'd0);
        wr_ctrl_rdy = 1'b1;
        @(negedge clk);
        wr_ctrl_rdy = 1'b0;
    endtask

    task automatic check_desc(input string tag, input logic [31:0] b, input logic [31:0] e,
                              input logic [31:0] c, input logic [15:0] n);
        check({tag, "_begin"}, pkt_begin, b);
        check({tag, "_end"}, pkt_end, e);
        check({tag, "_addr"}, write_address, BASE + b);
        check({tag, "_control"}, control, c);
        check({tag, "_count"}, 32'(pkt_count), 32'(n));
    endtask

    initial begin
        reset       = 1'b1;
        capture_en  = 1'b1;
        st_data     = 32'd0;
        st_valid    = 1'b0;
        st_sop      = 1'b0;
        st_eop      = 1'b0;
        st_empty    = 2'd0;
        full        = 1'b0;
        wr_ctrl_rdy = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", 32'(st_ready), 32'd0);
        check("rst_wr_fifo", 32'(wr_to_fifo), 32'd0);
        check("rst_wr_ctrl", 32'(wr_ctrl), 32'd0);
        check("rst_control", control, 32'd0);
        check("rst_begin", pkt_begin, 32'd0);
        check("rst_end", pkt_end, 32'd0);
        check("rst_addr", write_address, BASE);
        check("rst_pkt_count", 32'(pkt_count), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("idle_ready", 32'(st_ready), 32'd1);

        // 100-byte packet
        send_pkt(8'h01, 100);
        wait_issue();
        check("p1_latency", cyc, 32'd1);
        check("p1_words", wq.size(), 32'd25);
        check("p1_first", wq[0], 32'h0100_0000);
        check("p1_last", wq[24], 32'h0100_0018);
        check_desc("p1", 32'd0, 32'd100, 32'd100, 16'd1);
        check("p1_issue_ready", 32'(st_ready), 32'd0);
        repeat (3) @(negedge clk);
        check("p1_hold_end", pkt_end, 32'd100);
        pulse_rdy();

        // 41-byte runt, padded to 64
        send_pkt(8'h02, 41);
        wait_issue();
        check("p2_latency", cyc, 32'd6);
        check("p2_words", wq.size(), 32'd16);
        check("p2_last_data", wq[10], 32'h0200_000A);
        errs = 0;
        for (int i = 11; i < 16; i++) if (wq.size() > i && wq[i] !== 32'd0) errs++;
        check("p2_pad_zero", errs, 32'd0);
        check_desc("p2", 32'd100, 32'd164, 32'h0002_0029, 16'd2);
        check("p2_stored", pkt_end - pkt_begin, 32'd64);
        pulse_rdy();

        // 2000-byte packet, truncated to 1520
        send_pkt(8'h03, 2000);
        wait_issue();
        check("p3_words", wq.size(), 32'd380);
        check("p3_last", wq[379], 32'h0300_017B);
        check_desc("p3", 32'd164, 32'd1684, 32'h0001_07D0, 16'd3);
        pulse_rdy();

        // 1520-byte packet, then a packet arriving while its descriptor is outstanding
        send_pkt(8'h04, 1520);
        wait_issue();
        check_desc("p4", 32'd1684, 32'd3204, 32'h0000_05F0, 16'd4);
        @(negedge clk);
        send_pkt(8'h09, 32);
        repeat (2) @(negedge clk);
        #1;
        check("drop_words", wq.size(), 32'd0);
        check("drop_ready_held", stalls, 32'd0);
        check("drop_count_1", 32'(drop_count), 32'd1);
        check("drop_hold_begin", pkt_begin, 32'd1684);
        check("drop_pkt_count", 32'(pkt_count), 32'd4);
        pulse_rdy();

        // bring the offset to 3900
        send_pkt(8'h05, 696);
        wait_issue();
        check_desc("p5", 32'd3204, 32'd3900, 32'd696, 16'd5);
        pulse_rdy();

        // 300 bytes no longer fit before the ring end
        send_pkt(8'h06, 300);
        wait_issue();
        check_desc("p6_wrap", 32'd0, 32'd300, 32'd300, 16'd6);
        pulse_rdy();

        // FIFO full for 5 cycles mid-packet
        fork
            send_pkt(8'h07, 64);
            begin
                repeat (4) @(negedge clk);
                full = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    #1;
                    check("full_stall_ready", 32'(st_ready), 32'd0);
                    @(negedge clk);
                end
                full = 1'b0;
            end
        join
        wait_issue();
        check("p7_stalls", stalls, 32'd5);
        check("p7_words", wq.size(), 32'd16);
        errs = 0;
        for (int i = 0; i < 16; i++) if (wq.size() <= i || wq[i] !== {8'h07, 24'(i)}) errs++;
        check("p7_sequence", errs, 32'd0);
        check_desc("p7", 32'd300, 32'd364, 32'd64, 16'd7);
        pulse_rdy();

        // capture disabled: dropped without FIFO writes
        capture_en = 1'b0;
        send_pkt(8'h08, 8);
        repeat (2) @(negedge clk);
        #1;
        check("dis_words", wq.size(), 32'd0);
        check("dis_drop_count", 32'(drop_count), 32'd2);
        check("dis_pkt_count", 32'(pkt_count), 32'd7);
        capture_en = 1'b1;

        // reset in the middle of a capture
        wq.delete();
        beat(32'h0A00_0000, 1'b1, 1'b0, 2'd0);
        beat(32'h0A00_0001, 1'b0, 1'b0, 2'd0);
        beat(32'h0A00_0002, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        check("mid_wr_active", 32'(wr_to_fifo), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_ready", 32'(st_ready), 32'd0);
        check("mid_rst_wr_fifo", 32'(wr_to_fifo), 32'd0);
        check("mid_rst_wr_ctrl", 32'(wr_ctrl), 32'd0);
        check("mid_rst_control", control, 32'd0);
        check("mid_rst_begin", pkt_begin, 32'd0);
        check("mid_rst_end", pkt_end, 32'd0);
        check("mid_rst_addr", write_address, BASE);
        check("mid_rst_pkt_count", 32'(pkt_count), 32'd0);
        check("mid_rst_drop_count", 32'(drop_count), 32'd0);
        st_valid = 1'b0;
        st_sop   = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        send_pkt(8'h0B, 64);
        wait_issue();
        check("p11_words", wq.size(), 32'd16);
        check_desc("p11", 32'd0, 32'd64, 32'd64, 16'd1);
        pulse_rdy();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
